oht_dec_pipe: RTL
=================

// Module: oht_dec_pipe
// PURPOSE
//  Pipelined binary-index to one-hot decoder. It is the inverse of the pe* priority-encoder
//  family: it takes a binary index and returns the W-bit one-hot vector.
//  Sits where an encoded index (e.g. a pe1024 result) must drive a per-entry enable/clear
//  vector. Valid/ready on both sides, so it can sit between stall-capable stages.
//  Decode is two-level:
//    - coarse: top 2 index bits -> 4 group enables
//    - fine: the remaining LW-2 bits decoded within the selected W/4 quarter
//  An optional register sits between the two levels.
// PARAMETERS
//  W     1024  output vector width; power of 4, >= 16
//  LW    10    index width; must equal log2(W)
//  PIPE  1     1: register between coarse and fine decode (2-stage); 0: single stage
// PORTS
//  clk       in   1    clock, all state on rising edge
//  rst       in   1    asynchronous reset, ACTIVE-LOW (asserted when 0)
//  in_bin    in   LW   binary index to decode
//  in_vld    in   1    in_bin valid
//  in_rdy    out  1    decoder accepts in_bin this cycle (in_vld & in_rdy = transfer)
//  out_oht   out  W    one-hot result; exactly bit in_bin set
//  out_vld   out  1    out_oht valid
//  out_rdy   in   1    downstream accepts out_oht (out_vld & out_rdy = transfer)
// BEHAVIOUR
//  Reset (rst==0, async): all stage valids=0, out_vld=0, out_oht=0, in_rdy=1 (combinational from empty stages).
//    Data registers also clear to 0.
//  Stage S1 (present only when PIPE=1) registers:
//    - grp[3:0] = one-hot of in_bin[LW-1:LW-2]
//    - low[LW-3:0] = in_bin[LW-3:0]
//    - s1_vld
//  Stage S2 registers out_oht and out_vld.
//    - out_oht quarter q = grp[q] ? onehot(low) : 0
//    - onehot(low) is (W/4) bits wide.
//  Latency: in_bin accepted at edge N -> out_vld=1 with its out_oht after edge N+1 (PIPE=1) or after edge N (PIPE=0).
//  Advance rules (bubble-collapsing, no combinational path from in_vld to out_vld):
//    s2_adv  = !out_vld | out_rdy
//    s1_adv  = !s1_vld  | s2_adv
//    in_rdy  = s1_adv (PIPE=1) / s2_adv (PIPE=0)
//    - S2 loads S1 contents (or empty) when s2_adv.
//    - S1 loads input (valid = in_vld) when s1_adv.
//  Throughput: 1 index/cycle while out_rdy=1.
//  Capacity: 2 entries (PIPE=1). With out_rdy=0 and S2 full, S1 still fills, then in_rdy falls.
//  Stall: while out_vld=1 & out_rdy=0, out_oht and out_vld must hold stable (no change, no drop).
//  Simultaneous events: out_rdy=1 with full pipe and in_vld=1 -> S2 takes S1, S1 takes new input, same edge; in_rdy stays 1.
//  out_oht is always zero or exactly one-hot; zero whenever out_vld=0 after a drain (S2 loads 0 when taking a bubble).
//  Every LW-bit value 0..W-1 is legal; there is no out-of-range case.
//  Reset mid-operation: in-flight entries are discarded with no output transfer; first post-reset accept restarts at latency above.
//  in_bin is sampled only on transfer; value while in_vld=0 is don't-care.
// TESTING
//  1 Reset: rst=0 with in_vld=1 -> out_vld=0, out_oht=0, in_rdy=1; release rst, no spurious output.
//  2 Single decode, out_rdy=1:
//    - in_bin=0 -> out_oht=1<<0 two cycles later.
//    - in_bin=1023 -> bit 1023 only.
//    - in_bin=256 -> bit 256 only (quarter boundary).
//  3 Streaming: in_bin=0..1023 back-to-back, out_rdy=1 -> 1024 outputs, in order, one per cycle, each exactly one-hot at the index.
//  4 Backpressure: out_rdy=0, feed 5,6,7 -> out_oht=1<<5 held stable, in_rdy=0 after 2 accepts, 7 waits.
//    Release out_rdy -> 5,6,7 delivered in order, no loss or duplication.
//  5 Reset mid-stream: assert rst with 2 entries in flight -> out_vld=0 immediately; after release, in_bin=42 -> only 1<<42 emerges.
//  6 PIPE=0 build: in_bin=3 -> out_oht=1<<3 one cycle after accept; repeat tests 3-4 with capacity 1.

Source files
------------

// File: rtl/oht_dec_pipe.sv
// oht_dec_pipe: pipelined binary-index to one-hot decoder.
//
// Turns an LW-bit index into a W-bit vector with exactly bit in_bin set. The decode
// is split in two levels: the top two index bits select one of four W/4 quarters
// (coarse), the remaining LW-2 bits pick the bit inside that quarter (fine). With
// PIPE=1 a register stage (S1) sits between the two levels; S2 always registers
// the final vector. Valid/ready on both sides with bubble-collapsing advance.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active low
//   in_bin   in   [LW-1:0] index to decode, sampled only on in_vld & in_rdy
//   in_vld   in   in_bin valid
//   in_rdy   out  decoder can take in_bin this cycle
//   out_oht  out  [W-1:0] one-hot result (zero while out_vld=0)
//   out_vld  out  out_oht valid
//   out_rdy  in   downstream takes out_oht this cycle
module oht_dec_pipe #(
  parameter int unsigned W    = 1024,
  parameter int unsigned LW   = 10,
  parameter int unsigned PIPE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [LW-1:0] in_bin,
  input  logic          in_vld,
  output logic          in_rdy,
  output logic [W-1:0]  out_oht,
  output logic          out_vld,
  input  logic          out_rdy
);

  localparam int unsigned Q = W / 4;

  logic [3:0]    grp_dec;    // coarse decode of the incoming index
  logic [3:0]    stg_grp;    // coarse result feeding the fine level
  logic [LW-3:0] stg_low;    // low index bits feeding the fine level
  logic          stg_vld;
  logic          s2_adv;
  logic [Q-1:0]  fine;
  logic [W-1:0]  out_oht_d;
  logic [W-1:0]  out_oht_q;
  logic          out_vld_q;

  always_comb begin
    grp_dec = '0;
    grp_dec[in_bin[LW-1:LW-2]] = 1'b1;
  end

  assign s2_adv = !out_vld_q || out_rdy;

  if (PIPE != 0) begin : g_s1
    logic [3:0]    grp_q;
    logic [LW-3:0] low_q;
    logic          s1_vld_q;
    logic          s1_adv;

    assign s1_adv = !s1_vld_q || s2_adv;
    assign in_rdy = s1_adv;

    // A bubble loads zero data so S2 emits an all-zero vector when it drains.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        grp_q    <= '0;
        low_q    <= '0;
        s1_vld_q <= 1'b0;
      end else if (s1_adv) begin
        s1_vld_q <= in_vld;
        grp_q    <= in_vld ? grp_dec : 4'b0000;
        low_q    <= in_vld ? in_bin[LW-3:0] : '0;
      end
    end

    assign stg_grp = grp_q;
    assign stg_low = low_q;
    assign stg_vld = s1_vld_q;
  end else begin : g_no_s1
    assign in_rdy  = s2_adv;
    assign stg_grp = in_vld ? grp_dec : 4'b0000;
    assign stg_low = in_bin[LW-3:0];
    assign stg_vld = in_vld;
  end

  // Fine decode is shared by all quarters; the coarse enable picks which one shows it.
  always_comb begin
    fine = '0;
    fine[stg_low] = 1'b1;
    out_oht_d = '0;
    for (int q = 0; q < 4; q++) begin
      out_oht_d[q*Q +: Q] = stg_grp[q] ? fine : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld_q <= 1'b0;
      out_oht_q <= '0;
    end else if (s2_adv) begin
      out_vld_q <= stg_vld;
      out_oht_q <= out_oht_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_oht = out_oht_q;

endmodule
